// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Shares one 32x32 register-file write port between NUM_REQ writeback sources.
// Each source uses a valid/ready handshake. The grant is combinational. The
// write port (writeReg/writeData/regWrite) is registered, so it lags the
// transfer by one cycle. Writes aimed at register 0 are accepted but never
// reach the register file; drop_x0 flags them instead.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hold,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_addr,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [4:0]              writeReg,
    output logic [31:0]             writeData,
    output logic                    regWrite,
    output logic                    drop_x0
);
    localparam int            PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] grant_idx;
    logic          grant_vld;
    logic [4:0]    grant_addr;
    logic [31:0]   grant_data;

    logic [4:0]    write_reg_q, write_reg_d;
    logic [31:0]   write_data_q, write_data_d;
    logic          reg_write_q, reg_write_d;
    logic          drop_x0_q, drop_x0_d;

    // Choose the winner: lowest index in fixed mode, otherwise the first valid
    // requester at or after ptr. Both loops run from the far end so the
    // nearest candidate is written last and wins.
    always_comb begin
        int            cand;
        logic [PW-1:0] cand_idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        if (rst_n && !hold) begin
            if (FIXED_PRIO) begin
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (req_valid[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = PW'(i);
                    end
                end
            end else begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    cand = int'(ptr_q) + k;
                    if (cand >= NUM_REQ) begin
                        cand = cand - NUM_REQ;
                    end
                    cand_idx = PW'(cand);
                    if (req_valid[cand_idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = cand_idx;
                    end
                end
            end
        end
    end

    // Decode the grant to one-hot ready and steer the winner's address and data.
    always_comb begin
        req_ready  = '0;
        grant_addr = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && (grant_idx == PW'(i))) begin
                req_ready[i] = 1'b1;
                grant_addr   = req_addr[5*i +: 5];
                grant_data   = req_data[32*i +: 32];
            end
        end
    end

    // Next pointer and write-port contents. Address and data hold their last
    // values when nothing transfers; only the strobes drop.
    always_comb begin
        ptr_d        = ptr_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        drop_x0_d    = 1'b0;
        if (grant_vld) begin
            if (!FIXED_PRIO) begin
                ptr_d = (grant_idx == LAST) ? '0 : grant_idx + PW'(1);
            end
            write_reg_d  = grant_addr;
            write_data_d = grant_data;
            reg_write_d  = (grant_addr != 5'd0);
            drop_x0_d    = (grant_addr == 5'd0);
        end
    end

    // State registers. Reset cancels any in-flight write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            drop_x0_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            drop_x0_q    <= drop_x0_d;
        end
    end

    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign regWrite  = reg_write_q;
    assign drop_x0   = drop_x0_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: three instances (2-way round-robin, 3-way
// round-robin, 2-way fixed priority) share clk/rst_n. A reference model
// predicts the grant index and write-port contents for each instance.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        hold_a, hold_b, hold_f;
    logic [1:0]  valid_a, valid_f;
    logic [2:0]  valid_b;
    logic [9:0]  addr_a, addr_f;
    logic [14:0] addr_b;
    logic [63:0] data_a, data_f;
    logic [95:0] data_b;
    logic [1:0]  rdy_a, rdy_f;
    logic [2:0]  rdy_b;
    logic [4:0]  wr_a, wr_b, wr_f;
    logic [31:0] wd_a, wd_b, wd_f;
    logic        rw_a, rw_b, rw_f, dx_a, dx_b, dx_f;

    regfile_write_arbiter #(.NUM_REQ(2), .FIXED_PRIO(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .hold(hold_a), .req_valid(valid_a), .req_addr(addr_a),
        .req_data(data_a), .req_ready(rdy_a), .writeReg(wr_a), .writeData(wd_a),
        .regWrite(rw_a), .drop_x0(dx_a));
    regfile_write_arbiter #(.NUM_REQ(3), .FIXED_PRIO(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .hold(hold_b), .req_valid(valid_b), .req_addr(addr_b),
        .req_data(data_b), .req_ready(rdy_b), .writeReg(wr_b), .writeData(wd_b),
        .regWrite(rw_b), .drop_x0(dx_b));
    regfile_write_arbiter #(.NUM_REQ(2), .FIXED_PRIO(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .hold(hold_f), .req_valid(valid_f), .req_addr(addr_f),
        .req_data(data_f), .req_ready(rdy_f), .writeReg(wr_f), .writeData(wd_f),
        .regWrite(rw_f), .drop_x0(dx_f));

    // Register file fed by dut_a's write port.
    logic [31:0] rf_a [32];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_a[i] <= '0;
        end else if (rw_a) begin
            rf_a[wr_a] <= wd_a;
        end
    end

    // Stimulus per instance (0 = a, 1 = b, 2 = f) and model state.
    logic        s_hold  [3];
    logic [3:0]  s_valid [3];
    logic [4:0]  s_addr  [3][4];
    logic [31:0] s_data  [3][4];
    int          ptr     [3];
    int          exp_g   [3];
    logic [3:0]  exp_rdy [3], obs_rdy [3];
    logic [4:0]  e_wr [3], o_wr [3];
    logic [31:0] e_wd [3], o_wd [3];
    logic        e_rw [3], o_rw [3], e_dx [3], o_dx [3];
    int          wait_b [3];
    int          checks = 0;
    int          failures = 0;

    function automatic int nreq(input int w);
        return (w == 1) ? 3 : 2;
    endfunction

    // Reference grant: -1 when nothing is granted.
    function automatic int pick(input int w, input logic h, input logic [3:0] v);
        int n = nreq(w);
        if (h) return -1;
        if (w == 2) begin
            for (int i = 0; i < n; i++) if (v[i]) return i;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr[w] + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic reset_model();
        for (int w = 0; w < 3; w++) begin
            ptr[w] = 0; e_wr[w] = '0; e_wd[w] = '0; e_rw[w] = 1'b0; e_dx[w] = 1'b0;
        end
    endtask

    task automatic idle();
        for (int w = 0; w < 3; w++) begin
            s_hold[w] = 1'b0; s_valid[w] = 4'b0;
            for (int i = 0; i < 4; i++) begin s_addr[w][i] = '0; s_data[w][i] = '0; end
        end
    endtask

    task automatic apply();
        hold_a = s_hold[0]; valid_a = s_valid[0][1:0];
        addr_a = {s_addr[0][1], s_addr[0][0]}; data_a = {s_data[0][1], s_data[0][0]};
        hold_b = s_hold[1]; valid_b = s_valid[1][2:0];
        addr_b = {s_addr[1][2], s_addr[1][1], s_addr[1][0]};
        data_b = {s_data[1][2], s_data[1][1], s_data[1][0]};
        hold_f = s_hold[2]; valid_f = s_valid[2][1:0];
        addr_f = {s_addr[2][1], s_addr[2][0]}; data_f = {s_data[2][1], s_data[2][0]};
    endtask

    // One clock: drive at the falling edge, sample ready before the rising
    // edge, advance the model at the rising edge, sample outputs 1 ns later.
    task automatic cycle();
        apply();
        #1;
        for (int w = 0; w < 3; w++) begin
            exp_g[w]   = pick(w, s_hold[w], s_valid[w]);
            exp_rdy[w] = (exp_g[w] >= 0) ? 4'(1 << exp_g[w]) : 4'b0;
        end
        obs_rdy[0] = {2'b0, rdy_a}; obs_rdy[1] = {1'b0, rdy_b}; obs_rdy[2] = {2'b0, rdy_f};
        @(posedge clk);
        for (int w = 0; w < 3; w++) begin
            if (exp_g[w] >= 0) begin
                int g;
                g = exp_g[w];
                e_wr[w] = s_addr[w][g]; e_wd[w] = s_data[w][g];
                e_rw[w] = (s_addr[w][g] != 5'd0); e_dx[w] = (s_addr[w][g] == 5'd0);
                if (w != 2) ptr[w] = (g + 1) % nreq(w);
            end else begin
                e_rw[w] = 1'b0; e_dx[w] = 1'b0;
            end
        end
        #1;
        o_wr[0] = wr_a; o_wd[0] = wd_a; o_rw[0] = rw_a; o_dx[0] = dx_a;
        o_wr[1] = wr_b; o_wd[1] = wd_b; o_rw[1] = rw_b; o_dx[1] = dx_b;
        o_wr[2] = wr_f; o_wd[2] = wd_f; o_rw[2] = rw_f; o_dx[2] = dx_f;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle();
        for (int w = 0; w < 3; w++) s_valid[w] = 4'b0111;
        apply();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy_a, rdy_b, rdy_f, rw_a, dx_a, wr_a, wd_a} !== '0) begin
            failures++;
            $display("FAIL reset: rdy_a=%b rdy_b=%b rdy_f=%b rw=%b dx=%b wr=%0d wd=%h, required all zero",
                     rdy_a, rdy_b, rdy_f, rw_a, dx_a, wr_a, wd_a);
        end
        reset_model();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        s_valid[0] = 4'b0001; s_addr[0][0] = 5'd5; s_data[0][0] = 32'hDEADBEEF;
        cycle();
        checks++;
        if ({obs_rdy[0], o_rw[0], o_wr[0], o_wd[0]} !== {4'b0001, 1'b1, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_write: rdy=%b rw=%b wr=%0d wd=%h, required 0001/1/5/deadbeef",
                     obs_rdy[0], o_rw[0], o_wr[0], o_wd[0]);
        end
        s_valid[0] = 4'b0;
        cycle();
        checks++;
        if ({obs_rdy[0], o_rw[0], o_dx[0], o_wr[0], o_wd[0]} !== {exp_rdy[0], e_rw[0], e_dx[0], e_wr[0], e_wd[0]}) begin
            failures++;
            $display("FAIL single_idle: rdy=%b rw=%b dx=%b wr=%0d wd=%h, required %b/%b/%b/%0d/%h",
                     obs_rdy[0], o_rw[0], o_dx[0], o_wr[0], o_wd[0], exp_rdy[0], e_rw[0], e_dx[0], e_wr[0], e_wd[0]);
        end
    endtask

    task automatic test_x0_discard();
        s_valid[0] = 4'b0010; s_addr[0][1] = 5'd0; s_data[0][1] = 32'h1234;
        cycle();
        checks++;
        if ({obs_rdy[0], o_rw[0], o_dx[0]} !== {4'b0010, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL x0_discard: rdy=%b rw=%b dx=%b, required 0010/0/1", obs_rdy[0], o_rw[0], o_dx[0]);
        end
        s_valid[0] = 4'b0;
        cycle();
        checks++;
        if ({o_dx[0], rf_a[0]} !== {1'b0, 32'h0}) begin
            failures++;
            $display("FAIL x0_after: dx=%b rf0=%h, required 0/00000000", o_dx[0], rf_a[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] seq [4];
        seq[0] = 5'd1; seq[1] = 5'd2; seq[2] = 5'd1; seq[3] = 5'd2;
        s_valid[0] = 4'b0011;
        s_addr[0][0] = 5'd1; s_data[0][0] = 32'h11;
        s_addr[0][1] = 5'd2; s_data[0][1] = 32'h22;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if ({obs_rdy[0], o_rw[0], o_wr[0], o_wd[0]} !== {exp_rdy[0], 1'b1, seq[c], e_wd[0]}) begin
                failures++;
                $display("FAIL round_robin[%0d]: rdy=%b rw=%b wr=%0d wd=%h, required %b/1/%0d/%h",
                         c, obs_rdy[0], o_rw[0], o_wr[0], o_wd[0], exp_rdy[0], seq[c], e_wd[0]);
            end
        end
        s_valid[0] = 4'b0;
    endtask

    task automatic test_hold();
        s_valid[0] = 4'b0001; s_addr[0][0] = 5'd3; s_data[0][0] = 32'h33;
        cycle();
        s_hold[0] = 1'b1; s_valid[0] = 4'b0011;
        s_addr[0][1] = 5'd4; s_data[0][1] = 32'h44;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if ({obs_rdy[0], o_rw[0]} !== 5'b0) begin
                failures++;
                $display("FAIL hold[%0d]: rdy=%b rw=%b, required 00/0", c, obs_rdy[0], o_rw[0]);
            end
        end
        checks++;
        if (rf_a[3] !== 32'h33) begin
            failures++;
            $display("FAIL hold_inflight: rf3=%h, required 00000033", rf_a[3]);
        end
        s_hold[0] = 1'b0;
        cycle();
        checks++;
        if ({obs_rdy[0], o_wr[0], o_wd[0]} !== {4'b0010, 5'd4, 32'h44}) begin
            failures++;
            $display("FAIL hold_release: rdy=%b wr=%0d wd=%h, required 0010/4/00000044", obs_rdy[0], o_wr[0], o_wd[0]);
        end
        s_valid[0] = 4'b0;
    endtask

    task automatic test_reset_midstream();
        s_valid[0] = 4'b0001; s_addr[0][0] = 5'd9; s_data[0][0] = 32'h99;
        s_addr[0][1] = 5'd10; s_data[0][1] = 32'hAA;
        cycle();
        checks++;
        if (o_rw[0] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: rw=%b, required 1", o_rw[0]);
        end
        s_valid[0] = 4'b0011;
        apply();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rw_a, dx_a, rdy_a} !== 4'b0) begin
            failures++;
            $display("FAIL midreset_cancel: rw=%b dx=%b rdy=%b, required 0/0/00", rw_a, dx_a, rdy_a);
        end
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        checks++;
        if ({obs_rdy[0], o_wr[0], o_rw[0]} !== {4'b0001, 5'd9, 1'b1}) begin
            failures++;
            $display("FAIL midreset_regrant: rdy=%b wr=%0d rw=%b, required 0001/9/1", obs_rdy[0], o_wr[0], o_rw[0]);
        end
        s_valid[0] = 4'b0;
    endtask

    task automatic test_same_addr();
        logic [31:0] last;
        last = '0;
        s_valid[0] = 4'b0011;
        s_addr[0][0] = 5'd7; s_data[0][0] = 32'hA0A0_0001;
        s_addr[0][1] = 5'd7; s_data[0][1] = 32'hB0B0_0002;
        for (int c = 0; c < 2; c++) begin
            cycle();
            checks++;
            if ({obs_rdy[0], o_rw[0], o_wr[0], o_wd[0]} !== {exp_rdy[0], e_rw[0], e_wr[0], e_wd[0]}) begin
                failures++;
                $display("FAIL same_addr[%0d]: rdy=%b rw=%b wr=%0d wd=%h, required %b/%b/%0d/%h",
                         c, obs_rdy[0], o_rw[0], o_wr[0], o_wd[0], exp_rdy[0], e_rw[0], e_wr[0], e_wd[0]);
            end
            if (exp_g[0] >= 0) begin
                last = s_data[0][exp_g[0]];
                s_valid[0][exp_g[0]] = 1'b0;
            end
        end
        cycle();
        checks++;
        if (rf_a[7] !== last) begin
            failures++;
            $display("FAIL same_addr_final: rf7=%h, required %h", rf_a[7], last);
        end
    endtask

    task automatic test_fixed_prio();
        s_valid[2] = 4'b0011;
        s_addr[2][0] = 5'd12; s_data[2][0] = 32'hC0;
        s_addr[2][1] = 5'd13; s_data[2][1] = 32'hD0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if ({obs_rdy[2], o_rw[2], o_wr[2], o_wd[2]} !== {4'b0001, 1'b1, 5'd12, 32'hC0}) begin
                failures++;
                $display("FAIL fixed_prio[%0d]: rdy=%b rw=%b wr=%0d wd=%h, required 0001/1/12/000000c0",
                         c, obs_rdy[2], o_rw[2], o_wr[2], o_wd[2]);
            end
        end
        s_valid[2] = 4'b0;
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 3; i++) wait_b[i] = 0;
        for (int c = 0; c < 300; c++) begin
            for (int w = 0; w < 3; w++) begin
                s_hold[w] = ($urandom_range(0, 4) == 0);
                for (int i = 0; i < nreq(w); i++) begin
                    if (!s_valid[w][i] && ($urandom_range(0, 2) != 0)) begin
                        s_valid[w][i] = 1'b1;
                        s_addr[w][i]  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                        s_data[w][i]  = $urandom;
                    end
                end
            end
            cycle();
            for (int w = 0; w < 3; w++) begin
                checks++;
                if ({obs_rdy[w], o_rw[w], o_dx[w], o_wr[w], o_wd[w]} !== {exp_rdy[w], e_rw[w], e_dx[w], e_wr[w], e_wd[w]}) begin
                    failures++;
                    $display("FAIL random[%0d] dut%0d: rdy=%b rw=%b dx=%b wr=%0d wd=%h, required %b/%b/%b/%0d/%h",
                             c, w, obs_rdy[w], o_rw[w], o_dx[w], o_wr[w], o_wd[w],
                             exp_rdy[w], e_rw[w], e_dx[w], e_wr[w], e_wd[w]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (s_valid[1][i] && !s_hold[1]) begin
                    if (obs_rdy[1][i]) begin
                        wait_b[i] = 0;
                    end else begin
                        wait_b[i]++;
                        checks++;
                        if (wait_b[i] >= 3) begin
                            failures++;
                            $display("FAIL starvation req%0d: waited %0d cycles, required < 3", i, wait_b[i]);
                        end
                    end
                end
            end
            for (int w = 0; w < 3; w++) begin
                if (exp_g[w] >= 0) s_valid[w][exp_g[w]] = 1'b0;
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_write();
        test_x0_discard();
        test_round_robin();
        test_hold();
        test_reset_midstream();
        test_same_addr();
        test_fixed_prio();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between NUM_REQ writeback sources, for example ALU writeback and load writeback.
- Each source uses a valid/ready handshake. The block grants at most one source per cycle, round-robin by default.
- It drives the register file write port (writeReg, writeData, regWrite) from registered outputs.
- Writes to register 0 are accepted and silently discarded, so register 0 stays at zero.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, where the lowest index wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
- hold  input  1  when 1, no grants are issued (pipeline freeze).
- req_valid  input  NUM_REQ  bit i = requester i has a write pending.
- req_addr  input  5*NUM_REQ  slice [5i+4:5i] = destination register of requester i.
- req_data  input  32*NUM_REQ  slice [32i+31:32i] = write data of requester i.
- req_ready  output  NUM_REQ  one-hot or zero; combinational grant to requester i.
- writeReg  output  5  register file write address (registered).
- writeData  output  32  register file write data (registered).
- regWrite  output  1  register file write enable (registered).
- drop_x0  output  1  pulses 1 for one cycle after an accepted write to register 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - regWrite=0, writeReg=0, writeData=0, drop_x0=0.
  - Round-robin pointer = 0, so requester 0 is first in priority.
  - req_ready is 0 while rst_n=0.
- Grant (combinational, same cycle):
  - If hold=1 or no req_valid bit is set, req_ready=0.
  - Otherwise exactly one req_ready bit is 1, always on a requester with req_valid=1.
  - req_ready depends only on req_valid, hold and the pointer, never on addr or data.
- Transfer: happens when req_valid[i] and req_ready[i] are both 1 at a rising edge.
  - The requester must hold valid, addr and data stable until it is granted.
  - It may drop valid only after the transfer.
- Round-robin (FIXED_PRIO=0):
  - Search order is ptr, ptr+1, ..., NUM_REQ-1, then 0, ..., ptr-1.
  - After a transfer from requester g, ptr <= (g+1) mod NUM_REQ.
  - ptr is unchanged when there is no transfer, including while hold=1.
  - Guarantee: a continuously valid requester is granted within NUM_REQ cycles of hold being low.
- Fixed priority (FIXED_PRIO=1): the lowest-index valid requester always wins; ptr is unused.
- Output latency is 1 cycle.
  - Transfer of (a,d) at edge k gives writeReg=a, writeData=d and regWrite=(a!=0) during cycle k+1, so the register file writes at edge k+1.
  - drop_x0=(a==0) during cycle k+1.
- No transfer at edge k gives regWrite=0 and drop_x0=0 in cycle k+1. writeReg and writeData keep their last values.
- Back-to-back transfers produce back-to-back writes; there is no bubble.
- hold rising while a write is in the output register: that write still completes. Hold only blocks new grants.
- Simultaneous requests to the same address: the granted one is written first and the other follows in a later cycle, so the last-granted value wins.
- Reset asserted mid-operation: the in-flight output write is cancelled (regWrite forced to 0 immediately) and ptr returns to 0. Requesters must re-present after reset.
- Arithmetic: ptr width is clog2(NUM_REQ), with explicit wrap at NUM_REQ (not a power-of-2 overflow).

Test Plan:
- Reset then single write: req_valid=01, addr0=5, data0=0xDEADBEEF → req_ready=01 the same cycle. Next cycle regWrite=1, writeReg=5, writeData=0xDEADBEEF. The cycle after, regWrite=0.
- Round-robin contention: both valid continuously, R0 (addr 1, data 0x11), R1 (addr 2, data 0x22), 4 cycles → grant order R0,R1,R0,R1. writeReg sequence 1,2,1,2 with regWrite=1 on every cycle.
- x0 discard: R1 writes addr 0, data 0x1234 → req_ready[1]=1. Next cycle regWrite=0, drop_x0=1. Register 0 still reads 0.
- Hold:
  - hold=1 with both valid for 3 cycles → req_ready=00 and regWrite=0 in the following cycles.
  - Release hold → the grant goes to the requester at the unchanged ptr.
- Async reset mid-stream: assert rst_n=0 between edges while regWrite=1 → regWrite=0 immediately. After release, the first grant goes to R0 even if R1 was next before reset.
- FIXED_PRIO=1: both valid for 3 cycles → R0 is granted all 3 cycles and req_ready[1]=0 throughout.
